// File: rtl/llc_mem_req_queue.sv
// LLC-to-memory request queue with outstanding-read limit and a one-entry response stage.
// Optional issue statistics are enabled by defining LLC_MEMQ_STATS_EN.
module llc_mem_req_queue #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned MAX_RD    = 2,
  parameter int unsigned ADDR_BITS = 26,
  parameter int unsigned LINE_BITS = 128
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 llc_mem_req_valid,
  output logic                 llc_mem_req_ready,
  input  logic                 req_hwrite,
  input  logic [2:0]           req_hsize,
  input  logic [1:0]           req_hprot,
  input  logic [ADDR_BITS-1:0] req_addr,
  input  logic [LINE_BITS-1:0] req_line,
  output logic                 mem_req_valid,
  input  logic                 mem_req_ready,
  output logic                 mem_req_hwrite,
  output logic [2:0]           mem_req_hsize,
  output logic [1:0]           mem_req_hprot,
  output logic [ADDR_BITS-1:0] mem_req_addr,
  output logic [LINE_BITS-1:0] mem_req_line,
  input  logic                 mem_rsp_valid,
  output logic                 mem_rsp_ready,
  input  logic [LINE_BITS-1:0] mem_rsp_line,
  output logic                 llc_mem_rsp_valid,
  input  logic                 llc_mem_rsp_ready,
  output logic [LINE_BITS-1:0] llc_mem_rsp_line,
  output logic                 rsp_err,
  output logic [15:0]          stat_rd_cnt,
  output logic [15:0]          stat_wr_cnt
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned RdW  = $clog2(MAX_RD) + 1;

  typedef enum logic {RspEmpty, RspFull} rsp_state_e;

  logic                 hwrite_mem [DEPTH];
  logic [2:0]           hsize_mem  [DEPTH];
  logic [1:0]           hprot_mem  [DEPTH];
  logic [ADDR_BITS-1:0] addr_mem   [DEPTH];
  logic [LINE_BITS-1:0] line_mem   [DEPTH];

  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic [RdW-1:0]  rd_out_q, rd_out_d;
  rsp_state_e      rsp_state_q;
  logic            rsp_valid_q, rsp_ready_q, rsp_err_q;
  logic [LINE_BITS-1:0] rsp_line_q;

  logic head_rd, push, pop, rd_issue, rsp_hs;

  assign head_rd           = ~hwrite_mem[rptr_q];
  assign llc_mem_req_ready = (count_q < CntW'(DEPTH));
  // A read at the head stalls the whole queue once the read limit is reached.
  assign mem_req_valid     = (count_q != '0) && !(head_rd && (rd_out_q == RdW'(MAX_RD)));
  assign push              = llc_mem_req_valid & llc_mem_req_ready;
  assign pop               = mem_req_valid & mem_req_ready;
  assign rd_issue          = pop & head_rd;
  assign rsp_hs            = rsp_valid_q & llc_mem_rsp_ready;

  assign mem_req_hwrite = hwrite_mem[rptr_q];
  assign mem_req_hsize  = hsize_mem[rptr_q];
  assign mem_req_hprot  = hprot_mem[rptr_q];
  assign mem_req_addr   = addr_mem[rptr_q];
  assign mem_req_line   = line_mem[rptr_q];

  assign llc_mem_rsp_valid = rsp_valid_q;
  assign mem_rsp_ready     = rsp_ready_q;
  assign llc_mem_rsp_line  = rsp_line_q;
  assign rsp_err           = rsp_err_q;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    rd_out_d = rd_out_q;
    unique case ({rd_issue, rsp_hs})
      2'b10:   rd_out_d = rd_out_q + RdW'(1);
      2'b01:   rd_out_d = rd_out_q - RdW'(1);
      default: rd_out_d = rd_out_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      hwrite_mem[wptr_q] <= req_hwrite;
      hsize_mem[wptr_q]  <= req_hsize;
      hprot_mem[wptr_q]  <= req_hprot;
      addr_mem[wptr_q]   <= req_addr;
      line_mem[wptr_q]   <= req_line;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      rd_out_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PtrW'(1);
      if (pop)  rptr_q <= rptr_q + PtrW'(1);
      count_q  <= count_d;
      rd_out_q <= rd_out_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_state_q <= RspEmpty;
      rsp_valid_q <= 1'b0;
      rsp_ready_q <= 1'b1;
      rsp_err_q   <= 1'b0;
    end else begin
      unique case (rsp_state_q)
        RspEmpty: begin
          if (mem_rsp_valid) begin
            if (rd_out_q != '0) begin
              rsp_line_q  <= mem_rsp_line;
              rsp_state_q <= RspFull;
              rsp_valid_q <= 1'b1;
              rsp_ready_q <= 1'b0;
            end else begin
              // Response without an outstanding read: drop it and flag.
              rsp_err_q <= 1'b1;
            end
          end
        end
        RspFull: begin
          if (llc_mem_rsp_ready) begin
            rsp_state_q <= RspEmpty;
            rsp_valid_q <= 1'b0;
            rsp_ready_q <= 1'b1;
          end
        end
        default: rsp_state_q <= RspEmpty;
      endcase
    end
  end

`ifdef LLC_MEMQ_STATS_EN
  logic [15:0] stat_rd_q, stat_wr_q;
  logic        wr_issue;

  assign wr_issue = pop & ~head_rd;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_rd_q <= '0;
      stat_wr_q <= '0;
    end else begin
      if (rd_issue && (stat_rd_q != 16'hFFFF)) stat_rd_q <= stat_rd_q + 16'd1;
      if (wr_issue && (stat_wr_q != 16'hFFFF)) stat_wr_q <= stat_wr_q + 16'd1;
    end
  end

  assign stat_rd_cnt = stat_rd_q;
  assign stat_wr_cnt = stat_wr_q;
`else
  assign stat_rd_cnt = 16'd0;
  assign stat_wr_cnt = 16'd0;
`endif

endmodule
